// File: rtl/jpeg_rle_zrl_encoder.sv
// Purpose     : JPEG AC run-length stage; turns 64 zigzag coefficients per block into (run,size,amp) symbols with ZRL/EOB.
// Latency     : 1 cycle from accepted coefficient to registered symbol; zeros inside the block produce no symbol.
// Backpressure: in_ready = ACCEPT && (!out_valid || out_ready); DRAIN holds in_ready low for one output handshake per pending ZRL.
//
// Ports
//   clk, rst_n            single clock, synchronous active-low reset
//   in_valid/in_ready     coefficient handshake, in_coef is COEF_W two's complement, DC first
//   out_valid/out_ready   symbol handshake into the Huffman coder
//   out_run               zero run preceding the coefficient (15 on a ZRL)
//   out_size              JPEG category (bit length of |coef|)
//   out_amp               amplitude bits, LSB aligned, zero above out_size
//   out_dc/out_eob/out_last  DC term / end-of-block / final symbol of block
module jpeg_rle_zrl_encoder #(
  parameter int COEF_W = 12,
  parameter int SIZE_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_run,
  output logic [SIZE_W-1:0] out_size,
  output logic [COEF_W-1:0] out_amp,
  output logic              out_dc,
  output logic              out_eob,
  output logic              out_last
);

  localparam logic [0:0] ST_ACCEPT = 1'b0;
  localparam logic [0:0] ST_DRAIN  = 1'b1;

  localparam logic [COEF_W-1:0] COEF_ONE = {{(COEF_W-1){1'b0}}, 1'b1};

  // One entropy symbol as handed to the Huffman coder.
  typedef struct packed {
    logic [3:0]        run;
    logic [SIZE_W-1:0] size;
    logic [COEF_W-1:0] amp;
    logic              dc;
    logic              eob;
    logic              last;
  } sym_t;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [0:0] state;
  logic [5:0] idx;        // position of the next coefficient within the block
  logic [3:0] run_cnt;    // zeros since last emitted coefficient, modulo 16
  logic [1:0] zrl_cnt;    // completed 16-zero groups not yet emitted
  logic [1:0] drain_cnt;  // ZRLs still owed while in DRAIN, including the one on the output
  sym_t       hold_sym;   // coefficient waiting behind its ZRLs
  sym_t       out_sym;
  logic       out_vld_q;

  // ------------------------------------------------------------------
  // Handshakes
  // ------------------------------------------------------------------
  logic in_hs;
  logic out_hs;

  assign in_ready = (state == ST_ACCEPT) && (!out_vld_q || out_ready);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_vld_q && out_ready;

  // ------------------------------------------------------------------
  // Coefficient classification and category
  // ------------------------------------------------------------------
  logic              is_dc;
  logic              is_last_idx;
  logic              is_zero;
  logic              is_neg;
  logic [COEF_W-1:0] mag;
  logic [COEF_W-1:0] amp_raw;
  logic [COEF_W-1:0] amp_mask;
  logic [SIZE_W-1:0] size_c;
  sym_t              coef_sym;
  sym_t              zrl_sym;
  sym_t              eob_sym;

  assign is_dc       = (idx == 6'd0);
  assign is_last_idx = (idx == 6'd63);
  assign is_zero     = (in_coef == '0);
  assign is_neg      = in_coef[COEF_W-1];

  always_comb begin
    // Magnitude is taken as unsigned so the most negative value maps to
    // 2^(COEF_W-1) and lands in category COEF_W.
    mag = is_neg ? (~in_coef + COEF_ONE) : in_coef;

    size_c = '0;
    for (int i = 0; i < COEF_W; i++) begin
      if (mag[i]) size_c = SIZE_W'(i + 1);
    end

    amp_mask = '0;
    for (int i = 0; i < COEF_W; i++) begin
      amp_mask[i] = (i < int'(size_c));
    end

    // Negative values are sent as v-1 (one's complement of |v|); the
    // wrap for the most negative value is harmless after masking.
    amp_raw = is_neg ? (in_coef - COEF_ONE) : in_coef;

    coef_sym      = '0;
    coef_sym.run  = is_dc ? 4'd0 : run_cnt;
    coef_sym.size = size_c;
    coef_sym.amp  = amp_raw & amp_mask;
    coef_sym.dc   = is_dc;
    coef_sym.last = is_last_idx;

    zrl_sym     = '0;
    zrl_sym.run = 4'd15;

    eob_sym      = '0;
    eob_sym.eob  = 1'b1;
    eob_sym.last = 1'b1;
  end

  // ------------------------------------------------------------------
  // Sequential control and output register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_ACCEPT;
      idx       <= '0;
      run_cnt   <= '0;
      zrl_cnt   <= '0;
      drain_cnt <= '0;
      hold_sym  <= '0;
      out_sym   <= '0;
      out_vld_q <= 1'b0;
    end else if (state == ST_DRAIN) begin
      // Input is blocked; each accepted ZRL is replaced by the next one,
      // and the last one by the held coefficient, so out_valid stays high.
      if (out_hs) begin
        drain_cnt <= drain_cnt - 2'd1;
        if (drain_cnt == 2'd1) begin
          out_sym <= hold_sym;
          state   <= ST_ACCEPT;
        end else begin
          out_sym <= zrl_sym;
        end
      end
    end else if (in_hs) begin
      idx <= idx + 6'd1;
      if (is_dc) begin
        run_cnt   <= '0;
        zrl_cnt   <= '0;
        out_sym   <= coef_sym;
        out_vld_q <= 1'b1;
      end else if (is_zero) begin
        if (is_last_idx) begin
          // Trailing zeros collapse into EOB; pending ZRLs are dropped.
          run_cnt   <= '0;
          zrl_cnt   <= '0;
          out_sym   <= eob_sym;
          out_vld_q <= 1'b1;
        end else begin
          if (run_cnt == 4'd15) begin
            run_cnt <= '0;
            if (zrl_cnt != 2'd3) zrl_cnt <= zrl_cnt + 2'd1;
          end else begin
            run_cnt <= run_cnt + 4'd1;
          end
          if (out_hs) out_vld_q <= 1'b0;
        end
      end else begin
        run_cnt   <= '0;
        zrl_cnt   <= '0;
        out_vld_q <= 1'b1;
        if (zrl_cnt == 2'd0) begin
          out_sym <= coef_sym;
        end else begin
          // The first ZRL goes out now; the coefficient waits in hold_sym.
          hold_sym  <= coef_sym;
          out_sym   <= zrl_sym;
          drain_cnt <= zrl_cnt;
          state     <= ST_DRAIN;
        end
      end
    end else if (out_hs) begin
      out_vld_q <= 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign out_valid = out_vld_q;
  assign out_run   = out_sym.run;
  assign out_size  = out_sym.size;
  assign out_amp   = out_sym.amp;
  assign out_dc    = out_sym.dc;
  assign out_eob   = out_sym.eob;
  assign out_last  = out_sym.last;

endmodule

// File: tb/tb_jpeg_rle_zrl_encoder.sv
// Purpose     : self-checking bench for jpeg_rle_zrl_encoder.
// Latency     : inputs driven 1 ns after posedge, outputs sampled on negedge.
// Backpressure: out_ready driven per cycle (always 1, toggling, random or held 0).
`timescale 1ns/1ps
module tb_jpeg_rle_zrl_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_coef = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_run;
  logic [3:0]  out_size;
  logic [11:0] out_amp;
  logic        out_dc;
  logic        out_eob;
  logic        out_last;

  always #5 clk = ~clk;

  jpeg_rle_zrl_encoder #(.COEF_W(12), .SIZE_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_run   (out_run),
    .out_size  (out_size),
    .out_amp   (out_amp),
    .out_dc    (out_dc),
    .out_eob   (out_eob),
    .out_last  (out_last)
  );

  typedef struct packed {
    logic [3:0]  run;
    logic [3:0]  size;
    logic [11:0] amp;
    logic        dc;
    logic        eob;
    logic        last;
  } sym_t;

  typedef struct {
    int coef;
    int exp_size;
    int exp_amp;
  } cat_vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random, 3: held low
  int   low_cnt;
  int   blk[64];
  sym_t exp_q[$];
  sym_t cap_q[$];
  sym_t cur_sym;
  sym_t prev_sym;
  bit   prev_stall = 1'b0;

  assign cur_sym = {out_run, out_size, out_amp, out_dc, out_eob, out_last};

  // out_ready changes 2 ns after posedge so the main flow can switch mode at +1 ns.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Capture every handshaken symbol and check that stalled symbols hold.
  always @(negedge clk) begin
    if (prev_stall) begin
      n_tests++;
      if (cur_sym !== prev_sym || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold: got sym=%h valid=%b, required sym=%h valid=1", cur_sym, out_valid, prev_sym);
      end
    end
    if (rst_n && out_valid && out_ready) cap_q.push_back(cur_sym);
    prev_stall = rst_n && out_valid && !out_ready;
    prev_sym   = cur_sym;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic push_exp(input int run, input int size, input int amp, input bit dc, input bit eob, input bit last);
    exp_q.push_back({4'(run), 4'(size), 12'(amp), dc, eob, last});
  endtask

  task automatic check_syms(input string name);
    check({name, "_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_tests++;
      if (cap_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s sym%0d: got run=%0d size=%0d amp=%h dc=%b eob=%b last=%b, required run=%0d size=%0d amp=%h dc=%b eob=%b last=%b",
                 name, i, cap_q[i].run, cap_q[i].size, cap_q[i].amp, cap_q[i].dc, cap_q[i].eob, cap_q[i].last,
                 exp_q[i].run, exp_q[i].size, exp_q[i].amp, exp_q[i].dc, exp_q[i].eob, exp_q[i].last);
      end
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  // Reference: JPEG symbol for value v after a run of zeros.
  function automatic sym_t mk(input int run, input int v, input bit dc, input bit eob, input bit last);
    sym_t s;
    int a, sz, m;
    a  = (v < 0) ? -v : v;
    sz = 0;
    while ((1 << sz) <= a) sz++;
    m  = (v > 0) ? v : v - 1;
    m  = m & ((1 << sz) - 1);
    s.run  = run[3:0];
    s.size = sz[3:0];
    s.amp  = m[11:0];
    s.dc   = dc;
    s.eob  = eob;
    s.last = last;
    return s;
  endfunction

  // Reference: whole block at once, from the gaps between non-zero ACs.
  task automatic model_block();
    int lastnz, run;
    exp_q.push_back(mk(0, blk[0], 1'b1, 1'b0, 1'b0));
    lastnz = 0;
    for (int i = 1; i < 64; i++) if (blk[i] != 0) lastnz = i;
    run = 0;
    for (int i = 1; i <= lastnz; i++) begin
      if (blk[i] == 0) begin
        run++;
      end else begin
        while (run > 15) begin
          exp_q.push_back(mk(15, 0, 1'b0, 1'b0, 1'b0));
          run -= 16;
        end
        exp_q.push_back(mk(run, blk[i], 1'b0, 1'b0, i == 63));
        run = 0;
      end
    end
    if (lastnz < 63) exp_q.push_back(mk(0, 0, 1'b0, 1'b1, 1'b1));
  endtask

  task automatic send(input int c);
    bit ok;
    int guard;
    in_valid = 1'b1;
    in_coef  = 12'(c);
    ok    = 1'b0;
    guard = 0;
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = in_ready;
      if (!ok) low_cnt++;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0 for 200 cycles, required 1");
    end
  endtask

  task automatic send_block(input bit gaps);
    for (int i = 0; i < 64; i++) begin
      if (gaps && $urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
      send(blk[i]);
    end
  endtask

  task automatic flush();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (out_valid && g < 300);
    @(posedge clk);
    #1;
    if (g >= 300) begin
      n_tests++;
      n_fail++;
      $display("FAIL flush_timeout: out_valid got 1 after 300 cycles, required 0");
    end
  endtask

  task automatic count_ready_low();
    int g;
    g = 0;
    low_cnt = 0;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      low_cnt++;
      g++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr_blk();
    for (int i = 0; i < 64; i++) blk[i] = 0;
  endtask

  initial begin
    cat_vec_t cat_tab[13];
    int       dens_tab[4];
    sym_t     s0, s1;
    int       exp_n;

    cat_tab[0]  = '{0,     0, 0};
    cat_tab[1]  = '{1,     1, 1};
    cat_tab[2]  = '{-1,    1, 0};
    cat_tab[3]  = '{2,     2, 2};
    cat_tab[4]  = '{-2,    2, 1};
    cat_tab[5]  = '{5,     3, 5};
    cat_tab[6]  = '{-7,    3, 0};
    cat_tab[7]  = '{255,   8, 255};
    cat_tab[8]  = '{-256,  9, 255};
    cat_tab[9]  = '{1024, 11, 1024};
    cat_tab[10] = '{2047, 11, 2047};
    cat_tab[11] = '{-2047, 11, 0};
    cat_tab[12] = '{-2048, 12, 2047};
    dens_tab    = '{0, 5, 25, 90};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_fields", cur_sym, 0);
    @(posedge clk);
    #1;

    // Category/amplitude table: value as DC and again as AC1
    rdy_mode = 0;
    for (int t = 0; t < 13; t++) begin
      clr_blk();
      blk[0] = cat_tab[t].coef;
      blk[1] = cat_tab[t].coef;
      send_block(1'b0);
      flush();
      exp_n = (cat_tab[t].coef != 0) ? 3 : 2;
      check($sformatf("cat%0d_count", t), cap_q.size(), exp_n);
      s0 = (cap_q.size() > 0) ? cap_q[0] : '0;
      s1 = (cap_q.size() > 1) ? cap_q[1] : '0;
      check($sformatf("cat%0d_dc_size", t), s0.size, cat_tab[t].exp_size);
      check($sformatf("cat%0d_dc_amp", t), s0.amp, cat_tab[t].exp_amp);
      check($sformatf("cat%0d_dc_flag", t), s0.dc, 1);
      if (cat_tab[t].coef != 0) begin
        check($sformatf("cat%0d_ac_size", t), s1.size, cat_tab[t].exp_size);
        check($sformatf("cat%0d_ac_amp", t), s1.amp, cat_tab[t].exp_amp);
        check($sformatf("cat%0d_ac_run", t), s1.run, 0);
      end
      cap_q.delete();
    end

    // Case 1, two blocks back to back: no idle cycle, in_ready never low
    clr_blk();
    blk[0] = 5;
    low_cnt = 0;
    send_block(1'b0);
    send_block(1'b0);
    flush();
    check("case1_ready_low", low_cnt, 0);
    repeat (2) begin
      push_exp(0, 3, 5, 1, 0, 0);
      push_exp(0, 0, 0, 0, 1, 1);
    end
    check_syms("case1");

    // Case 2
    clr_blk();
    blk[0] = -3; blk[1] = 1; blk[2] = -2;
    send_block(1'b0);
    flush();
    push_exp(0, 2, 0, 1, 0, 0);
    push_exp(0, 1, 1, 0, 0, 0);
    push_exp(0, 2, 1, 0, 0, 0);
    push_exp(0, 0, 0, 0, 1, 1);
    check_syms("case2");

    // Case 3: one ZRL, in_ready low for exactly one cycle
    clr_blk();
    blk[21] = 7;
    low_cnt = 0;
    send_block(1'b0);
    flush();
    check("case3_ready_low", low_cnt, 1);
    push_exp(0, 0, 0, 1, 0, 0);
    push_exp(15, 0, 0, 0, 0, 0);
    push_exp(4, 3, 7, 0, 0, 0);
    push_exp(0, 0, 0, 0, 1, 1);
    check_syms("case3");

    // Case 4: three ZRLs before the final coefficient, no EOB
    clr_blk();
    blk[0] = 1; blk[63] = -1;
    send_block(1'b0);
    count_ready_low();
    check("case4_ready_low", low_cnt, 3);
    flush();
    push_exp(0, 1, 1, 1, 0, 0);
    repeat (3) push_exp(15, 0, 0, 0, 0, 0);
    push_exp(14, 1, 0, 0, 0, 1);
    check_syms("case4");

    // Case 5
    clr_blk();
    blk[0] = 1; blk[1] = 2;
    send_block(1'b0);
    flush();
    push_exp(0, 1, 1, 1, 0, 0);
    push_exp(0, 2, 2, 0, 0, 0);
    push_exp(0, 0, 0, 0, 1, 1);
    check_syms("case5");

    // Case 6a: case 3 under 1010 backpressure
    rdy_mode = 1;
    clr_blk();
    blk[21] = 7;
    send_block(1'b0);
    flush();
    push_exp(0, 0, 0, 1, 0, 0);
    push_exp(15, 0, 0, 0, 0, 0);
    push_exp(4, 3, 7, 0, 0, 0);
    push_exp(0, 0, 0, 0, 1, 1);
    check_syms("case6_toggle");

    // Case 6b: reset while a ZRL is stalled in DRAIN
    rdy_mode = 0;
    clr_blk();
    blk[21] = 7;
    for (int i = 0; i <= 21; i++) send(blk[i]);
    rdy_mode = 3;
    @(negedge clk);
    check("drain_in_ready", in_ready, 0);
    check("drain_zrl_run", out_run, 15);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("drain_rst_out_valid", out_valid, 0);
    check("drain_rst_in_ready", in_ready, 1);
    rdy_mode = 0;
    @(posedge clk);
    #1;
    push_exp(0, 0, 0, 1, 0, 0);
    check_syms("pre_reset");
    clr_blk();
    blk[0] = 9; blk[5] = -1;
    send_block(1'b0);
    flush();
    push_exp(0, 4, 9, 1, 0, 0);
    push_exp(4, 1, 0, 0, 0, 0);
    push_exp(0, 0, 0, 0, 1, 1);
    check_syms("post_reset");

    // Random blocks, continuous, random backpressure and input gaps
    rdy_mode = 2;
    for (int b = 0; b < 40; b++) begin
      int dens;
      dens = dens_tab[$urandom_range(0, 3)];
      for (int i = 0; i < 64; i++) begin
        blk[i] = 0;
        if (i == 0 || $urandom_range(0, 99) < dens) begin
          if ($urandom_range(0, 3) == 0) blk[i] = int'($urandom_range(0, 4095)) - 2048;
          else                           blk[i] = int'($urandom_range(0, 14)) - 7;
        end
      end
      model_block();
      send_block(1'b1);
    end
    flush();
    check_syms("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jpeg_rle_zrl_encoder.md
# jpeg_rle_zrl_encoder

- Run-length / zero-run stage of the JPEG encoder RLE path.
- Consumes 64 zigzag-ordered quantized coefficients per 8x8 block, DC first.
- Emits JPEG entropy symbols `(run, size, amplitude)`, inserting ZRL (16-zero) symbols only when a later non-zero coefficient needs them, and replacing any trailing zeros with EOB.
- Its output feeds the Huffman coder. The amplitude it produces is the value the downstream amplitude registers capture.

## Interface
Parameters
- `COEF_W`, default 12: coefficient width, two's complement.
- `SIZE_W`, default 4: width of the size/category field.

Ports
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `in_valid`, in, 1: coefficient valid.
- `in_ready`, out, 1: stage accepts a coefficient this cycle.
- `in_coef`, in, `COEF_W`: quantized coefficient.
- `out_valid`, out, 1: symbol valid.
- `out_ready`, in, 1: downstream accepts the symbol.
- `out_run`, out, 4: zero run preceding the coefficient.
- `out_size`, out, `SIZE_W`: JPEG category (bit length of |coef|).
- `out_amp`, out, `COEF_W`: amplitude bits, LSB-aligned; bits above `out_size` are 0.
- `out_dc`, out, 1: symbol is the DC term.
- `out_eob`, out, 1: symbol is EOB.
- `out_last`, out, 1: final symbol of the block.

## Operation
- **Coefficient index.** An internal 6-bit index counts accepted coefficients. It wraps 63→0, and index 0 is DC.
- **Category.**
  - `size = ceil(log2(|v|+1))`; `size = 0` for `v = 0`.
  - `amp = v` if `v > 0`; `amp = v - 1` if `v < 0`; then masked to the low `size` bits.
  - Magnitude 2^(COEF_W-1) gives `size = COEF_W`.
- **DC (index 0).**
  - Always emits `run=0`, `size`, `amp`, `out_dc=1`, even when `v = 0`.
  - Clears the run and ZRL counters.
- **AC zero, index 1..62.** Consumed with no output.
  - `run` increments.
  - If `run` was 15, `run` becomes 0 and `zrl_cnt` increments (max 3).
- **AC zero, index 63.** Emits EOB: `run=0`, `size=0`, `amp=0`, `out_eob=1`, `out_last=1`. Pending ZRLs and the run are discarded.
- **AC non-zero.**
  - If `zrl_cnt = 0`: emit `(run, size, amp)` directly.
  - Otherwise: latch the coefficient and run into a hold register, go to DRAIN, and emit `zrl_cnt` ZRL symbols (`run=15`, `size=0`, `amp=0`), then the held symbol.
  - Counters clear.
  - `out_last=1` iff index was 63.
- **State machine.**
  - ACCEPT: normal operation.
  - DRAIN: stays while ZRLs remain. Each output handshake decrements the remaining count. After the last ZRL is accepted, the held symbol is loaded and the state returns to ACCEPT.
- **Flags.** `out_dc`, `out_eob` and `out_last` are 0 on every symbol except where stated above.

## Timing
- **Reset values.** `out_valid=0`; all output data fields and flags are 0; index, `run` and `zrl_cnt` are 0; state is ACCEPT; `in_ready` is 1 on the first cycle after reset. Reset takes effect on the clock edge with `rst_n=0`.
- **Output register.** Single-entry, registered.
  - Latency is 1 cycle: an input accepted at edge N gives a symbol visible after edge N.
  - Full throughput is 1 coefficient per cycle while `out_ready=1`.
- **Input handshake.** `in_ready = (state==ACCEPT) && (!out_valid || out_ready)`. This holds for zeros too, even though zeros produce no output.
- **Output handshake.** Output fields hold stable while `out_valid && !out_ready`. `out_valid` drops only after a handshake with no new symbol to load.
- **DRAIN cost.** With `k` pending ZRLs, DRAIN holds `in_ready=0` for `k` output handshakes. The held symbol appears in the cycle after the last ZRL is accepted.
- **Simultaneous events.** Handshake and new load in the same cycle: the new symbol replaces the old one, and `out_valid` stays 1.
- **Block boundary.** The next block's DC is accepted on the cycle after index 63 is accepted, provided the conditions above allow it. There are no idle cycles between blocks.
- **Reset mid-block or mid-DRAIN.** Held symbol and pending ZRLs are discarded, and the next accepted coefficient is DC.

## Test plan
1. DC=5, then 63 zeros, `out_ready=1` → (0,3,5,dc) then EOB (0,0,0,eob,last); exactly 2 symbols, `in_ready` never low.
2. DC=-3, AC1=1, AC2=-2, 61 zeros → (0,2,0b00,dc), (0,1,1), (0,2,0b01), EOB with last.
3. DC=0, indices 1–20 zero, index 21 = 7, rest zero → (0,0,0,dc), ZRL (15,0,0), (4,3,7), EOB; `in_ready=0` for exactly 1 cycle after index 21.
4. DC=1, indices 1–62 zero, index 63 = -1 → (0,1,1,dc), three ZRLs, (14,1,0,last); no EOB.
5. DC=1, AC1=2, indices 2–63 zero → (0,1,1,dc), (0,2,2), EOB with last; no ZRL is ever emitted.
6. Backpressure and reset:
   - Run case 3 with `out_ready` toggling 1010…; every symbol stays stable until its handshake and the sequence matches case 3.
   - Then assert `rst_n=0` for 1 cycle during DRAIN: `out_valid=0` next cycle, and the next input is treated as DC.
